// File: rtl/huff_decode_ctrl.sv
// rtl/huff_decode_ctrl.sv - serial Huffman codeword parser driving an external lookUpTable
// Optional HUFF_ERR_CNT_EN adds errCount, a saturating count of illegal codewords.
module huff_decode_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        bitIn,
  input  logic        bitValid,
  output logic        bitReady,
  output logic        lutEnable,
  output logic [4:0]  lutSymbol,
  input  logic [4:0]  lutData,
  output logic [4:0]  dataOut,
  output logic        dataValid,
  input  logic        dataReady,
  output logic        codeErr,
  output logic [15:0] symCount
`ifdef HUFF_ERR_CNT_EN
  ,
  output logic [7:0]  errCount
`endif
);

  typedef enum logic [1:0] {
    PREFIX = 2'd0,
    SUFFIX = 2'd1,
    LOOKUP = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  ones_cnt;
  logic [2:0]  suf_left;
  logic [2:0]  suf_bits;
  logic [3:0]  suf_val;
  logic [4:0]  base;
  logic [4:0]  rank;
  logic        illegal;
  logic        bit_take;
  logic        prefix_done;
  logic        code_done;
  logic        sym_take;
  logic [15:0] sym_cnt_q;

  // Suffix value including the bit on the wire, so the rank is ready on the last-bit edge.
  always_comb begin
    suf_val = {suf_bits, bitIn};
    case (ones_cnt)
      3'd0:    base = 5'd0;
      3'd1:    base = 5'd2;
      3'd2:    base = 5'd6;
      3'd3:    base = 5'd14;
      default: base = 5'd30;
    endcase
    rank    = base + {1'b0, suf_val};
    illegal = (ones_cnt == 3'd4) && (suf_val > 4'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PREFIX;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    bitReady    = 1'b0;
    lutEnable   = 1'b0;
    dataValid   = 1'b0;
    bit_take    = 1'b0;
    prefix_done = 1'b0;
    code_done   = 1'b0;
    sym_take    = 1'b0;
    case (state)
      PREFIX: begin
        bitReady    = 1'b1;
        bit_take    = bitValid;
        prefix_done = bitValid && (!bitIn || (ones_cnt == 3'd3));
        if (prefix_done) begin
          state_next = SUFFIX;
        end
      end
      SUFFIX: begin
        bitReady  = 1'b1;
        bit_take  = bitValid;
        code_done = bitValid && (suf_left == 3'd1);
        if (code_done) begin
          state_next = illegal ? PREFIX : LOOKUP;
        end
      end
      LOOKUP: begin
        lutEnable  = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        dataValid = 1'b1;
        sym_take  = dataReady;
        if (dataReady) begin
          state_next = PREFIX;
        end
      end
      default: begin
        state_next = PREFIX;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ones_cnt  <= 3'd0;
      suf_left  <= 3'd0;
      suf_bits  <= 3'd0;
      lutSymbol <= 5'd0;
      dataOut   <= 5'd0;
      codeErr   <= 1'b0;
      sym_cnt_q <= 16'd0;
    end else begin
      codeErr <= 1'b0;
      if ((state == PREFIX) && bit_take) begin
        if (bitIn) begin
          ones_cnt <= ones_cnt + 3'd1;
        end
        if (prefix_done) begin
          suf_left <= bitIn ? 3'd4 : (ones_cnt + 3'd1);
          suf_bits <= 3'd0;
        end
      end
      if ((state == SUFFIX) && bit_take) begin
        suf_bits <= suf_val[2:0];
        suf_left <= suf_left - 3'd1;
        if (code_done) begin
          ones_cnt <= 3'd0;
          if (illegal) begin
            codeErr <= 1'b1;
          end else begin
            lutSymbol <= rank;
          end
        end
      end
      // lutData is only meaningful while the table is enabled.
      if (lutEnable) begin
        dataOut <= lutData;
      end
      if (sym_take) begin
        sym_cnt_q <= sym_cnt_q + 16'd1;
      end
    end
  end

  assign symCount = sym_cnt_q;

`ifdef HUFF_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if (code_done && illegal && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign errCount = err_cnt_q;
`endif

endmodule
